// File: rtl/lsi_wb_pkg.sv
// Shared definitions for the LSI-11 Wishbone bus-cycle engines: FSM state encoding
// and byte-lane geometry helpers derived from the data width.
package lsi_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BUS,
    ST_HOLD,
    ST_IACK
  } wb_state_t;

  // Number of byte lanes on a DW-bit bus.
  function automatic int nl_f(input int dw);
    return (dw / 8 < 1) ? 1 : dw / 8;
  endfunction

  // Lane index width; never below 1 so adr[LW-1:0] stays a legal slice.
  function automatic int lw_f(input int dw);
    return (nl_f(dw) <= 2) ? 1 : $clog2(nl_f(dw));
  endfunction

endpackage

// File: rtl/lsi_wbm_ctl_if.sv
// Core request/response strobes plus the master and interrupt-vector Wishbone buses.
// The engine takes the master modport; the core/bus side takes the slave modport.
interface lsi_wbm_ctl_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();

  logic                             req_stb;
  logic                             req_we;
  logic                             req_byte;
  logic                             req_lock;
  logic                             req_iak;
  logic [AW-1:0]                    req_adr;
  logic [DW-1:0]                    req_dat;
  logic                             req_rdy;
  logic                             rsp_done;
  logic                             rsp_err;
  logic [DW-1:0]                    rsp_dat;
  logic                             berr_st;
  logic                             berr_clr;
  logic                             wbm_gnt_i;
  logic [AW-1:0]                    wbm_adr_o;
  logic [DW-1:0]                    wbm_dat_o;
  logic [DW-1:0]                    wbm_dat_i;
  logic                             wbm_cyc_o;
  logic                             wbm_we_o;
  logic [lsi_wb_pkg::nl_f(DW)-1:0]  wbm_sel_o;
  logic                             wbm_stb_o;
  logic                             wbm_ack_i;
  logic [DW-1:0]                    wbi_dat_i;
  logic                             wbi_ack_i;
  logic                             wbi_stb_o;

  modport master (
    input  req_stb, req_we, req_byte, req_lock, req_iak, req_adr, req_dat, berr_clr,
    input  wbm_gnt_i, wbm_dat_i, wbm_ack_i, wbi_dat_i, wbi_ack_i,
    output req_rdy, rsp_done, rsp_err, rsp_dat, berr_st,
    output wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbi_stb_o
  );

  modport slave (
    output req_stb, req_we, req_byte, req_lock, req_iak, req_adr, req_dat, berr_clr,
    output wbm_gnt_i, wbm_dat_i, wbm_ack_i, wbi_dat_i, wbi_ack_i,
    input  req_rdy, rsp_done, rsp_err, rsp_dat, berr_st,
    input  wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbi_stb_o
  );

endinterface

// File: rtl/lsi_wb_qtim.sv
// Saturating TW-bit bus-timeout counter; tc flags the enabled cycle whose increment
// reaches 2^TW-1, so the owner can abort on that same edge. Clear beats enable.
module lsi_wb_qtim #(
  parameter int TW = 6
) (
  input  logic vm_clk_p,
  input  logic vm_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TW-1:0] TMAX = '1;

  logic [TW-1:0] cnt;

  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != TMAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt >= TMAX - 1'b1);

endmodule

// File: rtl/lsi_wbm_ctl.sv
// Wishbone bus-cycle engine (read/write/locked RMW/vector fetch); request to rsp_done
// is 2 cycles with zero-wait ack. Requests are taken only while req_rdy (IDLE or HOLD).
module lsi_wbm_ctl
  import lsi_wb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TW      = 6,
  parameter int SLOW_EN = 1
) (
  input  logic vm_clk_p,
  input  logic vm_rst_n,
  input  logic vm_clk_ena,
  input  logic vm_clk_slow,
  lsi_wbm_ctl_if.master bus
);

  localparam int NL = nl_f(DW);
  localparam int LW = lw_f(DW);

  wb_state_t     st_q, st_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, wbi_q, wbi_d;
  logic          done_q, done_d, err_q, err_d, berr_q, berr_d;
  logic          lock_q, lock_d, iak_q, iak_d;
  logic [NL-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dato_q, dato_d, rdat_q, rdat_d;

  logic slow_act, req_rdy, acc, strobe, tc;

  function automatic logic [NL-1:0] sel_f(input logic byte_acc, input logic [AW-1:0] a);
    if (!byte_acc || NL == 1) return '1;
    return NL'(1) << a[LW-1:0];
  endfunction

  assign slow_act = (SLOW_EN != 0) && vm_clk_slow;
  assign req_rdy  = (st_q == ST_IDLE) || (st_q == ST_HOLD);
  assign acc      = req_rdy && bus.req_stb;
  assign strobe   = stb_q || wbi_q;

  lsi_wb_qtim #(.TW(TW)) u_qtim (
    .vm_clk_p (vm_clk_p),
    .vm_rst_n (vm_rst_n),
    .clr      (!strobe),
    .en       (strobe && bus.wbm_gnt_i),
    .tc       (tc)
  );

  always_comb begin
    st_d   = st_q;
    cyc_d  = cyc_q;
    stb_d  = stb_q;
    we_d   = we_q;
    wbi_d  = wbi_q;
    sel_d  = sel_q;
    adr_d  = adr_q;
    dato_d = dato_q;
    rdat_d = rdat_q;
    lock_d = lock_q;
    iak_d  = iak_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    berr_d = berr_q && !bus.berr_clr;
    unique case (st_q)
      ST_IDLE, ST_HOLD: begin
        if (acc) begin
          iak_d = bus.req_iak;
          if (bus.req_iak) begin
            // A vector fetch never runs under a held master cycle.
            cyc_d  = 1'b0;
            lock_d = 1'b0;
            if (slow_act) begin
              st_d = ST_WAIT;
            end else begin
              st_d  = ST_IACK;
              wbi_d = 1'b1;
            end
          end else begin
            adr_d  = bus.req_adr;
            dato_d = bus.req_dat;
            we_d   = bus.req_we;
            sel_d  = sel_f(bus.req_byte, bus.req_adr);
            lock_d = bus.req_lock && !bus.req_we;
            // Inside a locked sequence cyc is already up, so throttling is skipped.
            if ((st_q == ST_IDLE) && slow_act) begin
              st_d = ST_WAIT;
            end else begin
              st_d  = ST_BUS;
              cyc_d = 1'b1;
              stb_d = 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        if (vm_clk_ena || !slow_act) begin
          if (iak_q) begin
            st_d  = ST_IACK;
            wbi_d = 1'b1;
          end else begin
            st_d  = ST_BUS;
            cyc_d = 1'b1;
            stb_d = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (bus.wbm_ack_i) begin
          stb_d  = 1'b0;
          done_d = 1'b1;
          if (!we_q) rdat_d = bus.wbm_dat_i;
          if (lock_q) begin
            st_d = ST_HOLD;
          end else begin
            st_d  = ST_IDLE;
            cyc_d = 1'b0;
          end
        end else if (tc) begin
          st_d   = ST_IDLE;
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          lock_d = 1'b0;
          err_d  = 1'b1;
          berr_d = 1'b1;
        end
      end
      ST_IACK: begin
        if (bus.wbi_ack_i) begin
          st_d   = ST_IDLE;
          wbi_d  = 1'b0;
          done_d = 1'b1;
          rdat_d = bus.wbi_dat_i;
        end else if (tc) begin
          st_d   = ST_IDLE;
          wbi_d  = 1'b0;
          err_d  = 1'b1;
          berr_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n) begin
      st_q   <= ST_IDLE;
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      wbi_q  <= 1'b0;
      sel_q  <= '1;
      adr_q  <= '0;
      dato_q <= '0;
      rdat_q <= '0;
      lock_q <= 1'b0;
      iak_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cyc_q  <= cyc_d;
      stb_q  <= stb_d;
      we_q   <= we_d;
      wbi_q  <= wbi_d;
      sel_q  <= sel_d;
      adr_q  <= adr_d;
      dato_q <= dato_d;
      rdat_q <= rdat_d;
      lock_q <= lock_d;
      iak_q  <= iak_d;
      done_q <= done_d;
      err_q  <= err_d;
      berr_q <= berr_d;
    end
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.rsp_done  = done_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_dat   = rdat_q;
  assign bus.berr_st   = berr_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dato_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbi_stb_o = wbi_q;

endmodule

// File: tb/tb_lsi_wbm_ctl.sv
// Bench for lsi_wbm_ctl: a DW=16 slow-capable instance and a DW=32 instance built
// without the slow-clock throttle; responses are checked against a scoreboard queue.
module tb_lsi_wbm_ctl;

  logic vm_clk_p    = 1'b0;
  logic vm_rst_n    = 1'b0;
  logic vm_clk_ena  = 1'b0;
  logic vm_clk_slow = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [15:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;

  int   o_stb, o_wbi, o_cyc, o_cyc_low;
  logic o_done, o_err, o_tmo;
  bit   ena_run = 1'b0;
  int   ena_cnt = 0;

  lsi_wbm_ctl_if #(.AW(16), .DW(16)) bus16 ();
  lsi_wbm_ctl_if #(.AW(16), .DW(32)) bus32 ();

  lsi_wbm_ctl #(.AW(16), .DW(16), .TW(6), .SLOW_EN(1)) u_dut16 (
    .vm_clk_p    (vm_clk_p),
    .vm_rst_n    (vm_rst_n),
    .vm_clk_ena  (vm_clk_ena),
    .vm_clk_slow (vm_clk_slow),
    .bus         (bus16.master)
  );

  lsi_wbm_ctl #(.AW(16), .DW(32), .TW(4), .SLOW_EN(0)) u_dut32 (
    .vm_clk_p    (vm_clk_p),
    .vm_rst_n    (vm_rst_n),
    .vm_clk_ena  (vm_clk_ena),
    .vm_clk_slow (vm_clk_slow),
    .bus         (bus32.master)
  );

  always #5 vm_clk_p = ~vm_clk_p;

  // Slow-clock strobe: one cycle in eight, changing just after the rising edge.
  always @(posedge vm_clk_p) begin
    #1;
    if (ena_run) begin
      ena_cnt++;
      vm_clk_ena = (ena_cnt % 8 == 0);
    end else begin
      vm_clk_ena = 1'b0;
    end
  end

  // Scoreboard: every response pulse of the 16-bit engine pops one expectation.
  always @(negedge vm_clk_p) begin
    if (vm_rst_n && (bus16.rsp_done || bus16.rsp_err)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected done=%b err=%b dat=%h", bus16.rsp_done, bus16.rsp_err, bus16.rsp_dat);
      end else begin
        sb_e = exp_q.pop_front();
        if (bus16.rsp_err !== sb_e.err || bus16.rsp_done !== !sb_e.err ||
            (sb_e.chk && bus16.rsp_dat !== sb_e.dat))
          $display("FAIL sb_rsp got done=%b err=%b dat=%h exp err=%b dat=%h",
                   bus16.rsp_done, bus16.rsp_err, bus16.rsp_dat, sb_e.err, sb_e.dat);
        else n_pass++;
      end
    end
  end

  task automatic init_inputs;
    bus16.req_stb = 0; bus16.req_we = 0; bus16.req_byte = 0; bus16.req_lock = 0;
    bus16.req_iak = 0; bus16.req_adr = '0; bus16.req_dat = '0; bus16.berr_clr = 0;
    bus16.wbm_gnt_i = 1; bus16.wbm_dat_i = '0; bus16.wbm_ack_i = 0;
    bus16.wbi_dat_i = '0; bus16.wbi_ack_i = 0;
    bus32.req_stb = 0; bus32.req_we = 0; bus32.req_byte = 0; bus32.req_lock = 0;
    bus32.req_iak = 0; bus32.req_adr = '0; bus32.req_dat = '0; bus32.berr_clr = 0;
    bus32.wbm_gnt_i = 1; bus32.wbm_dat_i = '0; bus32.wbm_ack_i = 0;
    bus32.wbi_dat_i = '0; bus32.wbi_ack_i = 0;
  endtask

  // Called at a falling edge; holds req_stb for exactly one rising edge.
  task automatic issue(input logic we, input logic byt, input logic lock, input logic iak,
                       input logic [15:0] adr, input logic [15:0] dat);
    bus16.req_we = we; bus16.req_byte = byt; bus16.req_lock = lock; bus16.req_iak = iak;
    bus16.req_adr = adr; bus16.req_dat = dat; bus16.req_stb = 1'b1;
    @(negedge vm_clk_p);
    bus16.req_stb = 1'b0;
  endtask

  // Wishbone slave model: acks during the ack_at-th strobe cycle (0 = never) and
  // returns at the falling edge where rsp_done or rsp_err is first seen.
  task automatic serve(input int ack_at, input logic [15:0] rd);
    o_stb = 0; o_wbi = 0; o_cyc = 0; o_cyc_low = 0;
    o_done = 0; o_err = 0; o_tmo = 1;
    bus16.wbm_dat_i = rd; bus16.wbi_dat_i = rd;
    for (int i = 0; i < 300; i++) begin
      if (bus16.rsp_done || bus16.rsp_err) begin
        o_done = bus16.rsp_done; o_err = bus16.rsp_err; o_tmo = 0;
        break;
      end
      if (bus16.wbm_cyc_o) o_cyc++; else o_cyc_low++;
      if (bus16.wbm_stb_o) o_stb++;
      if (bus16.wbi_stb_o) o_wbi++;
      bus16.wbm_ack_i = bus16.wbm_stb_o && (o_stb == ack_at);
      bus16.wbi_ack_i = bus16.wbi_stb_o && (o_wbi == ack_at);
      @(negedge vm_clk_p);
    end
    bus16.wbm_ack_i = 0; bus16.wbi_ack_i = 0;
    if (o_tmo) begin
      n_chk++;
      $display("FAIL serve_bound no response within 300 cycles (required a response)");
    end
  endtask

  task automatic test_reset;
    vm_rst_n = 1'b0;
    repeat (2) @(negedge vm_clk_p);
    n_chk++; if ({bus16.wbm_cyc_o, bus16.wbm_stb_o, bus16.wbm_we_o, bus16.wbi_stb_o} !== 4'b0)
      $display("FAIL rst_ctl cyc/stb/we/wbi=%b required 0000", {bus16.wbm_cyc_o, bus16.wbm_stb_o, bus16.wbm_we_o, bus16.wbi_stb_o});
    else n_pass++;
    n_chk++; if ({bus16.rsp_done, bus16.rsp_err, bus16.berr_st} !== 3'b0)
      $display("FAIL rst_rsp done/err/berr=%b required 000", {bus16.rsp_done, bus16.rsp_err, bus16.berr_st});
    else n_pass++;
    n_chk++; if (bus16.wbm_sel_o !== 2'b11) $display("FAIL rst_sel16 got=%b exp=11", bus16.wbm_sel_o); else n_pass++;
    n_chk++; if (bus32.wbm_sel_o !== 4'hF) $display("FAIL rst_sel32 got=%h exp=f", bus32.wbm_sel_o); else n_pass++;
    n_chk++; if ({bus16.wbm_adr_o, bus16.wbm_dat_o, bus16.rsp_dat} !== 48'h0)
      $display("FAIL rst_data adr/dat/rsp=%h required 0", {bus16.wbm_adr_o, bus16.wbm_dat_o, bus16.rsp_dat});
    else n_pass++;
    vm_rst_n = 1'b1;
    @(negedge vm_clk_p);
    n_chk++; if (bus16.req_rdy !== 1'b1) $display("FAIL rst_rdy got=%b exp=1", bus16.req_rdy); else n_pass++;
  endtask

  task automatic test_read;
    exp_q.push_back('{err: 1'b0, chk: 1'b1, dat: 16'hA5C3});
    issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000);
    n_chk++; if (bus16.wbm_adr_o !== 16'h1000 || bus16.wbm_we_o !== 1'b0)
      $display("FAIL rd_adr got adr=%h we=%b exp adr=1000 we=0", bus16.wbm_adr_o, bus16.wbm_we_o);
    else n_pass++;
    serve(4, 16'hA5C3);
    n_chk++; if (o_cyc !== 4) $display("FAIL rd_cyc_len got=%0d exp=4", o_cyc); else n_pass++;
    n_chk++; if (o_cyc_low !== 0) $display("FAIL rd_done_lat extra cycles=%0d exp=0", o_cyc_low); else n_pass++;
    n_chk++; if (bus16.wbm_cyc_o !== 1'b0) $display("FAIL rd_cyc_drop got=%b exp=0", bus16.wbm_cyc_o); else n_pass++;
    @(negedge vm_clk_p);
    n_chk++; if (bus16.rsp_done !== 1'b0 || bus16.rsp_dat !== 16'hA5C3)
      $display("FAIL rd_hold got done=%b dat=%h exp done=0 dat=a5c3", bus16.rsp_done, bus16.rsp_dat);
    else n_pass++;
  endtask

  task automatic test_byte_write;
    exp_q.push_back('{err: 1'b0, chk: 1'b0, dat: 16'h0});
    issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0201, 16'h1200);
    n_chk++; if (bus16.wbm_sel_o !== 2'b10) $display("FAIL bw_sel got=%b exp=10", bus16.wbm_sel_o); else n_pass++;
    n_chk++; if (bus16.wbm_we_o !== 1'b1 || bus16.wbm_dat_o !== 16'h1200)
      $display("FAIL bw_dat got we=%b dat=%h exp we=1 dat=1200", bus16.wbm_we_o, bus16.wbm_dat_o);
    else n_pass++;
    serve(1, 16'h0000);
    exp_q.push_back('{err: 1'b0, chk: 1'b0, dat: 16'h0});
    issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0034);
    n_chk++; if (bus16.wbm_sel_o !== 2'b01) $display("FAIL bw_sel_lo got=%b exp=01", bus16.wbm_sel_o); else n_pass++;
    serve(1, 16'h0000);
    exp_q.push_back('{err: 1'b0, chk: 1'b0, dat: 16'h0});
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0201, 16'hBEAD);
    n_chk++; if (bus16.wbm_sel_o !== 2'b11) $display("FAIL ww_sel got=%b exp=11", bus16.wbm_sel_o); else n_pass++;
    serve(2, 16'h0000);
  endtask

  task automatic test_locked_rmw;
    exp_q.push_back('{err: 1'b0, chk: 1'b1, dat: 16'h3344});
    issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000);
    serve(1, 16'h3344);
    n_chk++; if (bus16.wbm_cyc_o !== 1'b1 || bus16.wbm_stb_o !== 1'b0 || bus16.req_rdy !== 1'b1)
      $display("FAIL rmw_hold got cyc=%b stb=%b rdy=%b exp 1 0 1", bus16.wbm_cyc_o, bus16.wbm_stb_o, bus16.req_rdy);
    else n_pass++;
    exp_q.push_back('{err: 1'b0, chk: 1'b0, dat: 16'h0});
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, 16'h3345);
    n_chk++; if (bus16.wbm_stb_o !== 1'b1 || bus16.wbm_we_o !== 1'b1)
      $display("FAIL rmw_wr_stb got stb=%b we=%b exp 1 1", bus16.wbm_stb_o, bus16.wbm_we_o);
    else n_pass++;
    serve(2, 16'h0000);
    n_chk++; if (o_cyc_low !== 0) $display("FAIL rmw_cyc_unbroken low cycles=%0d exp=0", o_cyc_low); else n_pass++;
    n_chk++; if (bus16.wbm_cyc_o !== 1'b0) $display("FAIL rmw_release got cyc=%b exp=0", bus16.wbm_cyc_o); else n_pass++;
  endtask

  task automatic test_busy_ignore;
    exp_q.push_back('{err: 1'b0, chk: 1'b1, dat: 16'h1111});
    issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h7777);
    serve(2, 16'h1111);
    repeat (3) @(negedge vm_clk_p);
    n_chk++; if (bus16.wbm_cyc_o !== 1'b0 || bus16.wbm_adr_o !== 16'h1234)
      $display("FAIL busy_ignore got cyc=%b adr=%h exp cyc=0 adr=1234", bus16.wbm_cyc_o, bus16.wbm_adr_o);
    else n_pass++;
  endtask

  task automatic test_timeout;
    exp_q.push_back('{err: 1'b1, chk: 1'b0, dat: 16'h0});
    issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0000);
    serve(0, 16'h0000);
    n_chk++; if (o_err !== 1'b1 || o_stb !== 63)
      $display("FAIL tmo_abort got err=%b stb_cycles=%0d exp err=1 stb_cycles=63", o_err, o_stb);
    else n_pass++;
    n_chk++; if (bus16.berr_st !== 1'b1 || bus16.wbm_cyc_o !== 1'b0)
      $display("FAIL tmo_berr got berr=%b cyc=%b exp 1 0", bus16.berr_st, bus16.wbm_cyc_o);
    else n_pass++;
    bus16.berr_clr = 1'b1;
    @(negedge vm_clk_p);
    bus16.berr_clr = 1'b0;
    n_chk++; if (bus16.berr_st !== 1'b0) $display("FAIL tmo_berr_clr got=%b exp=0", bus16.berr_st); else n_pass++;
    exp_q.push_back('{err: 1'b0, chk: 1'b1, dat: 16'hBEEF});
    issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h2002, 16'h0000);
    serve(63, 16'hBEEF);
    n_chk++; if (o_done !== 1'b1 || o_stb !== 63 || bus16.berr_st !== 1'b0)
      $display("FAIL tmo_ack_wins got done=%b stb_cycles=%0d berr=%b exp 1 63 0", o_done, o_stb, bus16.berr_st);
    else n_pass++;
  endtask

  task automatic test_slow;
    bit seen = 0, prev = 0, missed = 0, cyc_early = 0;
    vm_clk_slow = 1'b1;
    ena_run = 1'b1;
    repeat (3) @(negedge vm_clk_p);
    exp_q.push_back('{err: 1'b0, chk: 1'b1, dat: 16'h5A5A});
    issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0500, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      if (bus16.wbm_stb_o) begin
        seen = 1;
        break;
      end
      if (bus16.wbm_cyc_o) cyc_early = 1;
      if (prev) missed = 1;
      prev = vm_clk_ena;
      @(negedge vm_clk_p);
    end
    n_chk++; if (seen !== 1'b1 || prev !== 1'b1)
      $display("FAIL slow_start got seen=%b ena_before=%b exp 1 1", seen, prev);
    else n_pass++;
    n_chk++; if (missed !== 1'b0 || cyc_early !== 1'b0)
      $display("FAIL slow_wait got missed_ena=%b early_cyc=%b exp 0 0", missed, cyc_early);
    else n_pass++;
    serve(1, 16'h5A5A);
    vm_clk_slow = 1'b0;
    ena_run = 1'b0;
    @(negedge vm_clk_p);
  endtask

  task automatic test_iack;
    exp_q.push_back('{err: 1'b0, chk: 1'b1, dat: 16'h0060});
    issue(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    serve(2, 16'h0060);
    n_chk++; if (o_cyc !== 0 || bus16.wbm_cyc_o !== 1'b0)
      $display("FAIL iak_no_cyc got cyc_cycles=%0d exp=0", o_cyc);
    else n_pass++;
    n_chk++; if (o_wbi !== 2 || bus16.wbi_stb_o !== 1'b0)
      $display("FAIL iak_wbi got wbi_cycles=%0d stb_now=%b exp 2 0", o_wbi, bus16.wbi_stb_o);
    else n_pass++;
  endtask

  task automatic test_lanes_32;
    vm_clk_slow = 1'b1;
    bus32.req_we = 1'b1; bus32.req_byte = 1'b1; bus32.req_adr = 16'h0203;
    bus32.req_dat = 32'hAB00_0000; bus32.req_stb = 1'b1;
    @(negedge vm_clk_p);
    bus32.req_stb = 1'b0;
    n_chk++; if (bus32.wbm_stb_o !== 1'b1) $display("FAIL w32_no_throttle got stb=%b exp=1", bus32.wbm_stb_o); else n_pass++;
    n_chk++; if (bus32.wbm_sel_o !== 4'b1000) $display("FAIL w32_sel got=%b exp=1000", bus32.wbm_sel_o); else n_pass++;
    n_chk++; if (bus32.wbm_dat_o !== 32'hAB00_0000 || bus32.wbm_we_o !== 1'b1)
      $display("FAIL w32_dat got dat=%h we=%b exp ab000000 1", bus32.wbm_dat_o, bus32.wbm_we_o);
    else n_pass++;
    bus32.wbm_ack_i = 1'b1;
    @(negedge vm_clk_p);
    bus32.wbm_ack_i = 1'b0;
    n_chk++; if (bus32.rsp_done !== 1'b1 || bus32.wbm_cyc_o !== 1'b0)
      $display("FAIL w32_done got done=%b cyc=%b exp 1 0", bus32.rsp_done, bus32.wbm_cyc_o);
    else n_pass++;
    vm_clk_slow = 1'b0;
    @(negedge vm_clk_p);
  endtask

  task automatic test_reset_mid_bus;
    bit pulse = 0;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h3001, 16'h0000);
    @(negedge vm_clk_p);
    vm_rst_n = 1'b0;
    @(negedge vm_clk_p);
    n_chk++; if ({bus16.wbm_cyc_o, bus16.wbm_stb_o, bus16.rsp_done, bus16.rsp_err} !== 4'b0)
      $display("FAIL mid_rst_ctl cyc/stb/done/err=%b required 0000", {bus16.wbm_cyc_o, bus16.wbm_stb_o, bus16.rsp_done, bus16.rsp_err});
    else n_pass++;
    n_chk++; if (bus16.rsp_dat !== 16'h0 || bus16.wbm_adr_o !== 16'h0 || bus16.wbm_sel_o !== 2'b11)
      $display("FAIL mid_rst_data got rsp=%h adr=%h sel=%b exp 0 0 11", bus16.rsp_dat, bus16.wbm_adr_o, bus16.wbm_sel_o);
    else n_pass++;
    vm_rst_n = 1'b1;
    repeat (4) begin
      @(negedge vm_clk_p);
      if (bus16.rsp_done || bus16.rsp_err || bus16.wbm_cyc_o) pulse = 1;
    end
    n_chk++; if (pulse !== 1'b0 || bus16.req_rdy !== 1'b1)
      $display("FAIL mid_rst_quiet got activity=%b rdy=%b exp 0 1", pulse, bus16.req_rdy);
    else n_pass++;
  endtask

  initial begin
    init_inputs();
    @(negedge vm_clk_p);
    test_reset();
    test_read();
    test_byte_write();
    test_locked_rmw();
    test_busy_ignore();
    test_timeout();
    test_slow();
    test_iack();
    test_lanes_32();
    test_reset_mid_bus();
    n_chk++; if (exp_q.size() != 0) $display("FAIL sb_drain pending=%0d exp=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
